l1a_event_tagger: RTL

L1A_EVENT_TAGGER -- requirements
Module: l1a_event_tagger

---
 rtl/etroc2readout_pkg.sv | 15 +
 rtl/l1a_event_tagger_tagFifo.sv | 45 ++++
 rtl/l1a_event_tagger.sv | 77 +++++++
 3 files changed

// File: rtl/etroc2readout_pkg.sv
// etroc2readout_pkg: shared constants and types for the ETROC2 readout blocks
//   BC_MAX_DEFAULT : last BCID before wrap (3564 bunches per orbit)
//   BCID_W / EVT_W : bunch-counter and event-number field widths
//   syncState_t    : BCID synchronisation state
//   tag_t          : one L1A tag as stored in the tag FIFO
package etroc2readout_pkg;
  localparam int BC_MAX_DEFAULT = 3563;
  localparam int BCID_W = 12;
  localparam int EVT_W = 8;
  typedef enum logic {UNSYNC = 1'b0, SYNCED = 1'b1} syncState_t;
  typedef struct packed {
    logic [BCID_W-1:0] bcid;
    logic [EVT_W-1:0]  evt;
  } tag_t;
endpackage

// File: rtl/l1a_event_tagger_tagFifo.sv
// tagFifo: first-word-fall-through FIFO with synchronous flush
//   clk, rstn     : clock, asynchronous active-low reset
//   flush         : empties the FIFO (wins over push/pop)
//   push, wrData  : write request and data (ignored when full unless popping)
//   pop           : remove head (ignored when empty)
//   rdData        : head entry, forced to 0 while empty
//   empty, full   : occupancy flags
module tagFifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] rdData,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  logic doPush, doPop;
  // pointers carry one extra wrap bit so full and empty are distinguishable
  assign empty = wrPtr == rdPtr;
  assign full = wrPtr == {~rdPtr[AW], rdPtr[AW-1:0]};
  assign doPop = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign rdData = empty ? '0 : mem[rdPtr[AW-1:0]];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
    end
  always_ff @(posedge clk)
    if (doPush) mem[wrPtr[AW-1:0]] <= wrData;
endmodule

// File: rtl/l1a_event_tagger.sv
// l1a_event_tagger: bunch counter plus L1A event tagging into a readout FIFO
//   clk40, rstn        : 40 MHz clock, asynchronous active-low reset
//   fcBCR/fcL1A/fcL1ARst : decoded fast-command strobes
//   bcidOffset         : BCID loaded on BCR (values above BC_MAX load 0)
//   rdEn               : pop request from readout
//   bcidSynced, bcid   : sync status and current bunch counter
//   tagValid/tagBCID/tagEvent : FIFO head
//   fifoFull           : FIFO holds FIFO_DEPTH entries
//   l1aDropCount       : saturating count of L1As lost to overflow,
//                        present only with L1A_DROP_COUNT_EN defined (else 0)
module l1a_event_tagger
  import etroc2readout_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int BC_MAX = BC_MAX_DEFAULT
) (
  input  logic              clk40,
  input  logic              rstn,
  input  logic              fcBCR,
  input  logic              fcL1A,
  input  logic              fcL1ARst,
  input  logic [BCID_W-1:0] bcidOffset,
  input  logic              rdEn,
  output logic              bcidSynced,
  output logic [BCID_W-1:0] bcid,
  output logic              tagValid,
  output logic [BCID_W-1:0] tagBCID,
  output logic [EVT_W-1:0]  tagEvent,
  output logic              fifoFull,
  output logic [7:0]        l1aDropCount
);
  localparam logic [BCID_W-1:0] BC_LAST = BCID_W'(BC_MAX);
  syncState_t state, nextState;
  logic [EVT_W-1:0] eventCnt;
  logic accept, empty;
  tag_t pushTag, headTag;
  always_ff @(posedge clk40 or negedge rstn)
    if (!rstn) state <= UNSYNC;
    else state <= nextState;
  always_comb nextState = (state == UNSYNC && fcBCR) ? SYNCED : state;
  always_comb bcidSynced = state == SYNCED;
  always_ff @(posedge clk40 or negedge rstn)
    if (!rstn) bcid <= '0;
    else if (fcBCR) bcid <= bcidOffset > BC_LAST ? '0 : bcidOffset;
    else if (bcidSynced) bcid <= bcid == BC_LAST ? '0 : bcid + BCID_W'(1);
  // an L1A coincident with an event-counter reset is discarded outright
  assign accept = bcidSynced && fcL1A && !fcL1ARst;
  always_ff @(posedge clk40 or negedge rstn)
    if (!rstn) eventCnt <= '0;
    else if (fcL1ARst) eventCnt <= '0;
    else if (accept) eventCnt <= eventCnt + EVT_W'(1);
  // bcid here is still the pre-BCR value when fcBCR coincides with fcL1A
  assign pushTag = '{bcid: bcid, evt: eventCnt};
  tagFifo #(.WIDTH($bits(tag_t)), .DEPTH(FIFO_DEPTH)) uFifo (
    .clk(clk40),
    .rstn(rstn),
    .flush(fcL1ARst),
    .push(accept),
    .pop(rdEn),
    .wrData(pushTag),
    .rdData(headTag),
    .empty(empty),
    .full(fifoFull)
  );
  assign tagValid = !empty;
  assign tagBCID = headTag.bcid;
  assign tagEvent = headTag.evt;
`ifdef L1A_DROP_COUNT_EN
  logic drop;
  assign drop = accept && fifoFull && !(rdEn && tagValid);
  always_ff @(posedge clk40 or negedge rstn)
    if (!rstn) l1aDropCount <= '0;
    else if (drop && l1aDropCount != 8'hFF) l1aDropCount <= l1aDropCount + 8'd1;
`else
  assign l1aDropCount = '0;
`endif
endmodule
